// File: rtl/demux36_scan_ctrl.sv
// rtl/demux36_scan_ctrl.sv - 36-channel demux scan scheduler; define DEMUX36_SCAN_DIM_EN for duty dimming
module demux36_scan_ctrl #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned BLANK = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic        cont,
   input  logic [35:0] mask,
`ifdef DEMUX36_SCAN_DIM_EN
   input  logic [7:0]  duty,
`endif
   output logic [5:0]  sel,
   output logic        data_en,
   output logic        busy,
   output logic        frame_done
);

   localparam logic [7:0] DWELL_LD   = 8'(DWELL);
   localparam logic [3:0] BLANK_LD   = 4'(BLANK);
   localparam bit         BLANK_ZERO = (BLANK == 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_BLANK = 2'd2
   } state_t;

   state_t      state_q, state_n;
   logic [7:0]  dwell_q, dwell_n;
   logic [3:0]  blank_q, blank_n;
   logic [5:0]  sel_q, sel_n;
   logic [35:0] mask_q, mask_n;
   logic        frame_end;
   logic        advance;
   logic        data_en_n, busy_n, frame_done_n;
   logic [6:0]  nxt, first;

   // Lowest enabled channel at or above 'from'; result is {found, index}
   function automatic logic [6:0] find_from(input logic [35:0] m, input logic [6:0] from);
      logic [6:0] r;
      r = '0;
      for (int i = 35; i >= 0; i--) begin
         if (m[i] && (7'(i) >= from))
            r = {1'b1, 6'(i)};
      end
      return r;
   endfunction

   assign nxt   = find_from(mask_q, {1'b0, sel_q} + 7'd1);
   assign first = find_from(mask, 7'd0);

   // State register and per-channel datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         dwell_q <= '0;
         blank_q <= '0;
         sel_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_n;
         dwell_q <= dwell_n;
         blank_q <= blank_n;
         sel_q   <= sel_n;
         mask_q  <= mask_n;
      end
   end

   // Next state: dwell/blank countdown, channel stepping, frame end and abort
   always_comb begin
      state_n   = state_q;
      dwell_n   = dwell_q;
      blank_n   = blank_q;
      sel_n     = sel_q;
      mask_n    = mask_q;
      frame_end = 1'b0;
      advance   = 1'b0;
      if (stop) begin
         state_n = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mask_n = mask;
                  if (first[6]) begin
                     state_n = S_DRIVE;
                     sel_n   = first[5:0];
                     dwell_n = DWELL_LD;
                  end else begin
                     frame_end = 1'b1;
                  end
               end
            end
            S_DRIVE: begin
               if (dwell_q == 8'd1) begin
                  if (BLANK_ZERO) begin
                     advance = 1'b1;
                  end else begin
                     state_n = S_BLANK;
                     blank_n = BLANK_LD;
                  end
               end else begin
                  dwell_n = dwell_q - 8'd1;
               end
            end
            S_BLANK: begin
               if (blank_q == 4'd1)
                  advance = 1'b1;
               else
                  blank_n = blank_q - 4'd1;
            end
            default: state_n = S_IDLE;
         endcase
      end

      if (advance) begin
         if (nxt[6]) begin
            state_n = S_DRIVE;
            sel_n   = nxt[5:0];
            dwell_n = DWELL_LD;
         end else begin
            // Last channel done; continuous mode chains straight into the next frame
            frame_end = 1'b1;
            state_n   = S_IDLE;
            if (cont) begin
               mask_n = mask;
               if (first[6]) begin
                  state_n = S_DRIVE;
                  sel_n   = first[5:0];
                  dwell_n = DWELL_LD;
               end
            end
         end
      end
   end

   // Output values for the next cycle, derived from the next state
   always_comb begin
      busy_n       = (state_n != S_IDLE);
      frame_done_n = frame_end;
`ifdef DEMUX36_SCAN_DIM_EN
      data_en_n    = (state_n == S_DRIVE) &&
                     (({1'b0, DWELL_LD} - {1'b0, dwell_n}) < {1'b0, duty});
`else
      data_en_n    = (state_n == S_DRIVE);
`endif
   end

   // Registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_en    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         data_en    <= data_en_n;
         busy       <= busy_n;
         frame_done <= frame_done_n;
      end
   end

   assign sel = sel_q;

endmodule

// File: tb/tb_demux36_scan_ctrl.sv
// tb/tb_demux36_scan_ctrl.sv - directed self-checking bench for demux36_scan_ctrl
module tb_demux36_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, stop, cont;
   logic [35:0] mask;

   logic [5:0]  sel_a, sel_b;
   logic        data_en_a, busy_a, frame_done_a;
   logic        data_en_b, busy_b, frame_done_b;
`ifdef DEMUX36_SCAN_DIM_EN
   logic [7:0]  duty;
   logic [5:0]  sel_c;
   logic        data_en_c, busy_c, frame_done_c;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   demux36_scan_ctrl #(.DWELL(4), .BLANK(1)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .cont(cont), .mask(mask),
`ifdef DEMUX36_SCAN_DIM_EN
      .duty(8'hFF),
`endif
      .sel(sel_a), .data_en(data_en_a), .busy(busy_a), .frame_done(frame_done_a)
   );

   demux36_scan_ctrl #(.DWELL(2), .BLANK(0)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .cont(cont), .mask(mask),
`ifdef DEMUX36_SCAN_DIM_EN
      .duty(8'hFF),
`endif
      .sel(sel_b), .data_en(data_en_b), .busy(busy_b), .frame_done(frame_done_b)
   );

`ifdef DEMUX36_SCAN_DIM_EN
   demux36_scan_ctrl #(.DWELL(8), .BLANK(1)) u_dut_c (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .cont(cont), .mask(mask),
      .duty(duty),
      .sel(sel_c), .data_en(data_en_c), .busy(busy_c), .frame_done(frame_done_c)
   );
`endif

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle;
      start = 1'b0;
      cont  = 1'b0;
      stop  = 1'b1;
      tick();
      stop  = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      start = 1'b0; stop = 1'b0; cont = 1'b0; mask = '0;
      repeat (3) tick();
      checks++;
      if ({sel_a, data_en_a, busy_a, frame_done_a} !== 9'd0) begin
         errors++;
         $display("FAIL reset_a: got sel=%0d en=%b busy=%b done=%b, expected all 0",
                  sel_a, data_en_a, busy_a, frame_done_a);
      end
      checks++;
      if ({sel_b, data_en_b, busy_b, frame_done_b} !== 9'd0) begin
         errors++;
         $display("FAIL reset_b: got sel=%0d en=%b busy=%b done=%b, expected all 0",
                  sel_b, data_en_b, busy_b, frame_done_b);
      end
      reset_n = 1'b1;
      tick();
   endtask

   // mask 0x5, DWELL 4, BLANK 1: ch0 cycles 1-4, blank 5, ch2 6-9, blank 10, done at 11
   task automatic test_basic_frame;
      logic [5:0] es;
      logic       ee, eb, ed;
      mask = 36'h0_0000_0005;
      cont = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         tick();
         start = 1'b0;
         es = (c <= 5) ? 6'd0 : 6'd2;
         ee = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
         eb = (c <= 10);
         ed = (c == 11);
         checks++;
         if ({sel_a, data_en_a, busy_a, frame_done_a} !== {es, ee, eb, ed}) begin
            errors++;
            $display("FAIL basic_frame cyc %0d: got sel=%0d en=%b busy=%b done=%b, expected sel=%0d en=%b busy=%b done=%b",
                     c, sel_a, data_en_a, busy_a, frame_done_a, es, ee, eb, ed);
         end
      end
      go_idle();
   endtask

   // All channels, DWELL 2, BLANK 0, continuous: sel walks 0..35 then wraps with frame_done
   task automatic test_walk_cont;
      logic [5:0] es;
      logic       ed;
      mask = {36{1'b1}};
      cont = 1'b1;
      start = 1'b1;
      for (int c = 1; c <= 76; c++) begin
         tick();
         start = 1'b0;
         es = 6'(((c - 1) / 2) % 36);
         ed = (c == 73);
         checks++;
         if ({sel_b, data_en_b, busy_b, frame_done_b} !== {es, 1'b1, 1'b1, ed}) begin
            errors++;
            $display("FAIL walk_cont cyc %0d: got sel=%0d en=%b busy=%b done=%b, expected sel=%0d en=1 busy=1 done=%b",
                     c, sel_b, data_en_b, busy_b, frame_done_b, es, ed);
         end
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if ({sel_b, data_en_b, busy_b, frame_done_b} !== {6'd1, 3'b000}) begin
         errors++;
         $display("FAIL walk_stop: got sel=%0d en=%b busy=%b done=%b, expected sel=1 en=0 busy=0 done=0",
                  sel_b, data_en_b, busy_b, frame_done_b);
      end
      go_idle();
   endtask

   // Empty mask with cont=1: single frame_done pulse, never busy or driving
   task automatic test_empty_mask;
      mask = '0;
      cont = 1'b1;
      start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         start = 1'b0;
         checks++;
         if ({data_en_a, busy_a, frame_done_a} !== {1'b0, 1'b0, (c == 1)}) begin
            errors++;
            $display("FAIL empty_mask cyc %0d: got en=%b busy=%b done=%b, expected en=0 busy=0 done=%b",
                     c, data_en_a, busy_a, frame_done_a, (c == 1));
         end
      end
      go_idle();
   endtask

   // Stop on 2nd DRIVE cycle of channel 7, then stop+start together in IDLE
   task automatic test_stop;
      mask = 36'h0_0000_0080;
      cont = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({sel_a, data_en_a, busy_a, frame_done_a} !== {6'd7, 3'b110}) begin
         errors++;
         $display("FAIL stop_drive1: got sel=%0d en=%b busy=%b done=%b, expected sel=7 en=1 busy=1 done=0",
                  sel_a, data_en_a, busy_a, frame_done_a);
      end
      tick();
      checks++;
      if ({sel_a, data_en_a, busy_a} !== {6'd7, 2'b11}) begin
         errors++;
         $display("FAIL stop_drive2: got sel=%0d en=%b busy=%b, expected sel=7 en=1 busy=1",
                  sel_a, data_en_a, busy_a);
      end
      stop = 1'b1;
      tick();
      checks++;
      if ({sel_a, data_en_a, busy_a, frame_done_a} !== {6'd7, 3'b000}) begin
         errors++;
         $display("FAIL stop_abort: got sel=%0d en=%b busy=%b done=%b, expected sel=7 en=0 busy=0 done=0",
                  sel_a, data_en_a, busy_a, frame_done_a);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      checks++;
      if ({data_en_a, busy_a, frame_done_a} !== 3'b000) begin
         errors++;
         $display("FAIL stop_wins: got en=%b busy=%b done=%b, expected en=0 busy=0 done=0",
                  data_en_a, busy_a, frame_done_a);
      end
      for (int c = 1; c <= 10; c++) begin
         tick();
         checks++;
         if ({data_en_a, busy_a, frame_done_a} !== 3'b000) begin
            errors++;
            $display("FAIL stop_quiet cyc %0d: got en=%b busy=%b done=%b, expected en=0 busy=0 done=0",
                     c, data_en_a, busy_a, frame_done_a);
         end
      end
      go_idle();
   endtask

   // Mask change mid-frame only takes effect at the next continuous frame
   task automatic test_mask_change;
      logic [5:0] es;
      logic       ee, ed;
      mask = 36'h8_0000_0001;
      cont = 1'b1;
      start = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         start = 1'b0;
         mask = 36'h0_0000_0002;
         es = (c <= 5) ? 6'd0 : (c <= 10) ? 6'd35 : 6'd1;
         ee = (c >= 1 && c <= 4) || (c >= 6 && c <= 9) || (c >= 11 && c <= 14) || (c == 16);
         ed = (c == 11) || (c == 16);
         checks++;
         if ({sel_a, data_en_a, busy_a, frame_done_a} !== {es, ee, 1'b1, ed}) begin
            errors++;
            $display("FAIL mask_change cyc %0d: got sel=%0d en=%b busy=%b done=%b, expected sel=%0d en=%b busy=1 done=%b",
                     c, sel_a, data_en_a, busy_a, frame_done_a, es, ee, ed);
         end
      end
      go_idle();
   endtask

   // start while busy is ignored and not queued
   task automatic test_back_to_back;
      logic [5:0] es;
      logic       ee, eb, ed;
      mask = 36'h0_0000_0005;
      cont = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         tick();
         start = (c == 3);
         es = (c <= 5) ? 6'd0 : 6'd2;
         ee = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
         eb = (c <= 10);
         ed = (c == 11);
         checks++;
         if ({sel_a, data_en_a, busy_a, frame_done_a} !== {es, ee, eb, ed}) begin
            errors++;
            $display("FAIL back_to_back cyc %0d: got sel=%0d en=%b busy=%b done=%b, expected sel=%0d en=%b busy=%b done=%b",
                     c, sel_a, data_en_a, busy_a, frame_done_a, es, ee, eb, ed);
         end
      end
      go_idle();
   endtask

   // Reset asserted mid-frame clears outputs without a clock edge
   task automatic test_async_reset;
      mask = 36'h0_0000_0005;
      cont = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({sel_a, data_en_a, busy_a, frame_done_a} !== 9'd0) begin
         errors++;
         $display("FAIL async_reset: got sel=%0d en=%b busy=%b done=%b, expected all 0",
                  sel_a, data_en_a, busy_a, frame_done_a);
      end
      tick();
      reset_n = 1'b1;
      cont = 1'b0;
      tick();
   endtask

`ifdef DEMUX36_SCAN_DIM_EN
   // DWELL 8, BLANK 1, duty 3: 3 lit cycles per channel, frame length unchanged
   task automatic test_dim;
      logic [5:0] es;
      logic       ee, eb, ed;
      duty = 8'd3;
      mask = 36'h0_0000_0005;
      cont = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         start = 1'b0;
         es = (c <= 9) ? 6'd0 : 6'd2;
         ee = (c >= 1 && c <= 3) || (c >= 10 && c <= 12);
         eb = (c <= 18);
         ed = (c == 19);
         checks++;
         if ({sel_c, data_en_c, busy_c, frame_done_c} !== {es, ee, eb, ed}) begin
            errors++;
            $display("FAIL dim cyc %0d: got sel=%0d en=%b busy=%b done=%b, expected sel=%0d en=%b busy=%b done=%b",
                     c, sel_c, data_en_c, busy_c, frame_done_c, es, ee, eb, ed);
         end
      end
      go_idle();
   endtask
`endif

   initial begin
`ifdef DEMUX36_SCAN_DIM_EN
      duty = 8'd0;
`endif
      test_reset();
      test_basic_frame();
      test_walk_cont();
      test_empty_mask();
      test_stop();
      test_mask_change();
      test_back_to_back();
      test_async_reset();
`ifdef DEMUX36_SCAN_DIM_EN
      test_dim();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
